// File: rtl/uart_io_ctrl.sv
// UART I/O controller: CPU-facing TX/RX byte FIFOs with status registers.
// Ports: clk, rst (async active-low), re/we/sel/wdata/rdata CPU register port,
//   uart_din/_valid/_ready TX handshake, uart_dout/_valid/_ready RX handshake.
module uart_io_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  localparam int TAW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RAW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [4:0] TX_FULL = 5'(TX_DEPTH);
  localparam logic [4:0] RX_FULL = 5'(RX_DEPTH);

  // register decode
  logic sel_txs, sel_rxs, sel_rxd, sel_txd;
  assign sel_txs = (sel == 2'b00);
  assign sel_rxs = (sel == 2'b01);
  assign sel_rxd = (sel == 2'b10);
  assign sel_txd = (sel == 2'b11);

  // TX FIFO state
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_wptr_d;
  logic [TAW-1:0] tx_rptr_q, tx_rptr_d;
  logic [4:0]     tx_cnt_q, tx_cnt_d;
  logic           tx_drop_q, tx_drop_d;

  // RX FIFO state
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wptr_q, rx_wptr_d;
  logic [RAW-1:0] rx_rptr_q, rx_rptr_d;
  logic [4:0]     rx_cnt_q, rx_cnt_d;
  logic           rx_ovr_q, rx_ovr_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic [31:0]    rdata_q, rdata_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  assign tx_empty = (tx_cnt_q == 5'd0);
  assign tx_full  = (tx_cnt_q == TX_FULL);
  assign rx_empty = (rx_cnt_q == 5'd0);
  assign rx_full  = (rx_cnt_q == RX_FULL);

  // heads are gated so stale memory never leaks out after reset
  logic [7:0] tx_head, rx_head;
  assign tx_head = tx_empty ? 8'h00 : tx_mem[tx_rptr_q];
  assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];

  assign uart_din        = tx_head;
  assign uart_din_valid  = !tx_empty;
  assign uart_dout_ready = rst;

  // a pop frees a slot in the same cycle, so full+pop still accepts a push
  logic tx_pop, tx_req, tx_push, tx_lost, tx_clr;
  assign tx_pop  = uart_din_valid & uart_din_ready;
  assign tx_req  = we & sel_txd;
  assign tx_push = tx_req & (!tx_full | tx_pop);
  assign tx_lost = tx_req & !tx_push;
  assign tx_clr  = we & sel_txs & wdata[0];

  logic rx_pop, rx_push, rx_lost, rx_clr;
  assign rx_pop  = re & sel_rxd & !rx_empty;
  assign rx_push = uart_dout_valid & (!rx_full | rx_pop);
  assign rx_lost = uart_dout_valid & !rx_push;
  assign rx_clr  = we & sel_rxs & wdata[0];

  // TX next state
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    tx_drop_d = tx_drop_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 5'd1;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 5'd1;
    // set beats clear
    if (tx_lost)     tx_drop_d = 1'b1;
    else if (tx_clr) tx_drop_d = 1'b0;
  end

  // RX next state
  always_comb begin
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_cnt_d   = rx_cnt_q;
    rx_ovr_d   = rx_ovr_q;
    drop_cnt_d = drop_cnt_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 5'd1;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 5'd1;
    if (rx_lost) begin
      rx_ovr_d = 1'b1;
      if (rx_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (rx_clr) begin
      rx_ovr_d   = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // read mux; status reflects the pre-edge state
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      unique case (1'b1)
        sel_txs: rdata_d = {15'b0, tx_drop_q, 3'b0, tx_cnt_q,
                            6'b0, tx_empty, !tx_full};
        sel_rxs: rdata_d = {drop_cnt_q, 7'b0, rx_ovr_q, 3'b0,
                            rx_cnt_q, 7'b0, !rx_empty};
        sel_rxd: rdata_d = {24'b0, rx_head};
        sel_txd: rdata_d = 32'b0;
        default: rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_drop_q  <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_ovr_q   <= 1'b0;
      drop_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_drop_q  <= tx_drop_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ovr_q   <= rx_ovr_d;
      drop_cnt_q <= drop_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // storage needs no reset: counts gate every read
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= wdata;
    if (rx_push) rx_mem[rx_wptr_q] <= uart_dout;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl.
// Drives on falling edges, samples on falling edges.
module tb_uart_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [1:0]  sel;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready;
  logic [7:0]  uart_dout;
  logic        uart_dout_valid;
  logic        uart_dout_ready;

  int checks   = 0;
  int failures = 0;

  uart_io_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .re(re),
    .we(we),
    .sel(sel),
    .wdata(wdata),
    .rdata(rdata),
    .uart_din(uart_din),
    .uart_din_valid(uart_din_valid),
    .uart_din_ready(uart_din_ready),
    .uart_dout(uart_dout),
    .uart_dout_valid(uart_dout_valid),
    .uart_dout_ready(uart_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; sel = s; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [31:0] d);
    @(negedge clk);
    re = 1'b1; sel = s;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic inj(input logic [7:0] b);
    @(negedge clk);
    uart_dout = b; uart_dout_valid = 1'b1;
    @(negedge clk);
    uart_dout_valid = 1'b0;
  endtask

  logic [31:0] v;
  logic [7:0]  exp_b;

  initial begin
    rst = 1'b0; re = 1'b0; we = 1'b0; sel = 2'b00; wdata = 8'h00;
    uart_din_ready = 1'b0; uart_dout = 8'h00; uart_dout_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rdy_in_reset", {31'b0, uart_dout_ready}, 32'd0);
    rst = 1'b1;

    // 1: reset mid-operation
    wr(2'b11, 8'hAA);
    wr(2'b11, 8'hBB);
    inj(8'h11);
    rd(2'b00, v);
    chk("pre_rst_txs", v, 32'h0000_0201);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, uart_din_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_din", {24'b0, uart_din}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rdy_after", {31'b0, uart_dout_ready}, 32'd1);
    rd(2'b00, v);
    chk("rst_txs", v, 32'h0000_0003);
    rd(2'b01, v);
    chk("rst_rxs", v, 32'h0000_0000);

    // 2: TX order
    wr(2'b11, 8'h41);
    wr(2'b11, 8'h42);
    wr(2'b11, 8'h43);
    rd(2'b00, v);
    chk("tx3_status", v, 32'h0000_0301);
    chk("tx_hold", {23'b0, uart_din_valid, uart_din}, 32'h0000_0141);
    @(negedge clk);
    uart_din_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_b = 8'h41 + 8'(i);
      chk("tx_order", {23'b0, uart_din_valid, uart_din}, {23'b0, 1'b1, exp_b});
      @(negedge clk);
    end
    chk("tx_drained", {31'b0, uart_din_valid}, 32'd0);
    uart_din_ready = 1'b0;

    // 3: TX overflow
    for (int i = 0; i < 9; i++) wr(2'b11, 8'h10 + 8'(i));
    rd(2'b00, v);
    chk("tx_ovf", v, 32'h0001_0800);
    wr(2'b00, 8'h01);
    rd(2'b00, v);
    chk("tx_clr", v, 32'h0000_0800);
    @(negedge clk);
    uart_din_ready = 1'b1; we = 1'b1; sel = 2'b11; wdata = 8'h99;
    @(negedge clk);
    uart_din_ready = 1'b0; we = 1'b0;
    rd(2'b00, v);
    chk("tx_full_pp", v, 32'h0000_0800);
    @(negedge clk);
    uart_din_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_b = (i == 7) ? 8'h99 : 8'h11 + 8'(i);
      chk("tx_ovf_order", {24'b0, uart_din}, {24'b0, exp_b});
      @(negedge clk);
    end
    chk("tx_empty2", {31'b0, uart_din_valid}, 32'd0);
    uart_din_ready = 1'b0;

    // 4: RX read
    inj(8'h5A);
    rd(2'b01, v);
    chk("rx1_status", v, 32'h0000_0101);
    rd(2'b10, v);
    chk("rx_data", v, 32'h0000_005A);
    @(negedge clk);
    chk("rdata_hold", rdata, 32'h0000_005A);
    rd(2'b11, v);
    chk("txd_read", v, 32'h0000_0000);
    rd(2'b01, v);
    chk("rx0_status", v, 32'h0000_0000);
    rd(2'b10, v);
    chk("rx_empty_rd", v, 32'h0000_0000);
    wr(2'b10, 8'hFF);
    rd(2'b01, v);
    chk("rxd_wr_ign", v, 32'h0000_0000);

    // 5: RX overrun
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_dout = 8'h60 + 8'(i); uart_dout_valid = 1'b1;
      @(negedge clk);
    end
    uart_dout_valid = 1'b0;
    rd(2'b01, v);
    chk("rx_ovr", v, 32'h0201_0801);
    wr(2'b01, 8'h01);
    rd(2'b01, v);
    chk("rx_clr", v, 32'h0000_0801);

    // 6: concurrent CPU pop + UART push on a full FIFO
    @(negedge clk);
    re = 1'b1; sel = 2'b10; uart_dout = 8'h70; uart_dout_valid = 1'b1;
    @(negedge clk);
    re = 1'b0; uart_dout_valid = 1'b0;
    chk("rx_pp_data", rdata, 32'h0000_0060);
    rd(2'b01, v);
    chk("rx_pp_status", v, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      rd(2'b10, v);
      exp_b = (i == 7) ? 8'h70 : 8'h61 + 8'(i);
      chk("rx_order", v, {24'b0, exp_b});
    end
    @(negedge clk);
    uart_dout_valid = 1'b1;
    for (int i = 0; i < 308; i++) begin
      uart_dout = 8'(i);
      @(negedge clk);
    end
    uart_dout_valid = 1'b0;
    rd(2'b01, v);
    chk("drop_sat", v, 32'hFF01_0801);

    // clear in the same cycle as a drop: set wins
    @(negedge clk);
    we = 1'b1; sel = 2'b01; wdata = 8'h01; uart_dout_valid = 1'b1;
    @(negedge clk);
    we = 1'b0; uart_dout_valid = 1'b0;
    rd(2'b01, v);
    chk("clr_vs_drop", v, 32'h0101_0801);

    // simultaneous read and write
    @(negedge clk);
    re = 1'b1; we = 1'b1; sel = 2'b01; wdata = 8'h01;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    chk("re_we_read", rdata, 32'h0101_0801);
    rd(2'b01, v);
    chk("re_we_clr", v, 32'h0000_0801);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
